// File: rtl/uart_line_tx.sv
// uart_line_tx: FIFO-buffered 8N1/8N2 UART transmitter with a programmable bit period.
module uart_line_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_bits,
  input  logic [DIV_WIDTH-1:0]        div,
  input  logic                        nstop,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e                state_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DIV_WIDTH-1:0]  div_q, baud_q;
  logic [BW-1:0]         bit_q;
  logic                  nstop_q, txd_q, push, pop, bit_done, stop_done;
  assign in_ready = !reset && count_q != (AW+1)'(FIFO_DEPTH);
  assign txd      = txd_q;
  assign busy     = state_q != IDLE || count_q != '0;
  assign count    = count_q;
  // In STOP, bit_q[0] counts stop bits; the frame ends once it reaches nstop_q.
  always_comb begin
    push      = in_valid && in_ready;
    bit_done  = baud_q == div_q;
    stop_done = state_q == STOP && bit_done && bit_q[0] == nstop_q;
    pop       = count_q != '0 && (state_q == IDLE || stop_done);
    count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clock)
    if (push) mem_q[wr_q] <= in_bits;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      txd_q   <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      shift_q <= '0;
      div_q   <= '0;
      nstop_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) begin
        rd_q    <= rd_q + AW'(1);
        shift_q <= mem_q[rd_q];
        div_q   <= div;
        nstop_q <= nstop;
        baud_q  <= '0;
        bit_q   <= '0;
        state_q <= START;
        txd_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: txd_q <= 1'b1;
          START:
            if (bit_done) begin
              state_q <= DATA;
              txd_q   <= shift_q[0];
              baud_q  <= '0;
              bit_q   <= '0;
            end else baud_q <= baud_q + DIV_WIDTH'(1);
          DATA:
            if (bit_done) begin
              baud_q <= '0;
              if (bit_q == BW'(DATA_WIDTH-1)) begin
                state_q <= STOP;
                txd_q   <= 1'b1;
                bit_q   <= '0;
              end else begin
                bit_q   <= bit_q + BW'(1);
                shift_q <= shift_q >> 1;
                txd_q   <= shift_q[1];
              end
            end else baud_q <= baud_q + DIV_WIDTH'(1);
          STOP:
            if (bit_done) begin
              baud_q <= '0;
              if (stop_done) state_q <= IDLE;
              else bit_q <= bit_q + BW'(1);
            end else baud_q <= baud_q + DIV_WIDTH'(1);
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_line_tx.sv
// tb_uart_line_tx: directed checks of framing, FIFO handshake, back-to-back frames and reset abort.
module tb_uart_line_tx;
  logic        clock = 1'b0, reset = 1'b1, in_valid = 1'b0, nstop = 1'b0;
  logic        in_ready, txd, busy, acc;
  logic [7:0]  in_bits = '0;
  logic [15:0] div = '0;
  logic [2:0]  count;
  int          vectors = 0, miscompares = 0, k;
  uart_line_tx dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_bits(in_bits), .div(div), .nstop(nstop), .txd(txd), .busy(busy), .count(count)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Expected line level at cycle i of a frame carrying b with bit period d+1.
  function automatic logic exp_bit(input logic [7:0] b, input int d, input int i);
    int p;
    p = i / (d + 1);
    return p == 0 ? 1'b0 : p <= 8 ? b[p-1] : 1'b1;
  endfunction
  task automatic check_frame(input logic [7:0] b, input int d, input int from, input int to);
    for (int i = from; i < to; i++) begin
      chk($sformatf("txd_%h_c%0d", b, i), txd, exp_bit(b, d, i));
      chk($sformatf("busy_%h_c%0d", b, i), busy, 1);
      tick();
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 0);
    reset = 1'b0;
    #1 chk("ready_after_rst", in_ready, 1);
    // single 8N1 frame, div=3
    div = 16'd3;
    in_bits = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("a5_queued_count", count, 1);
    chk("a5_queued_txd", txd, 1);
    chk("a5_queued_busy", busy, 1);
    tick();
    check_frame(8'hA5, 3, 0, 40);
    chk("a5_done_busy", busy, 0);
    chk("a5_done_count", count, 0);
    chk("a5_done_txd", txd, 1);
    // three back-to-back frames, div=1
    div = 16'd1;
    in_bits = 8'h00;
    in_valid = 1'b1;
    tick();
    chk("b2b_ready0", in_ready, 1);
    in_bits = 8'hFF;
    tick();
    chk("b2b_start0", txd, 0);
    chk("b2b_ready1", in_ready, 1);
    in_bits = 8'h55;
    tick();
    chk("b2b_ready2", in_ready, 1);
    in_valid = 1'b0;
    check_frame(8'h00, 1, 1, 20);
    check_frame(8'hFF, 1, 0, 20);
    check_frame(8'h55, 1, 0, 20);
    chk("b2b_done_busy", busy, 0);
    // FIFO fill with in_valid held, div=9, bytes 1..8
    div = 16'd9;
    k = 1;
    in_bits = 8'd1;
    in_valid = 1'b1;
    for (int c = 1; c <= 802; c++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        k++;
        in_bits = 8'(k);
        if (k > 8) in_valid = 1'b0;
      end
      if (c == 4) begin
        chk("fill_acc4", k, 5);
        chk("fill_ready4", in_ready, 1);
      end
      if (c == 5) begin
        chk("fill_acc5", k, 6);
        chk("fill_count5", count, 4);
        chk("fill_ready5", in_ready, 0);
      end
      if (c == 101) chk("fill_ready_before_pop2", in_ready, 0);
      if (c == 102) begin
        chk("fill_ready_at_pop2", in_ready, 1);
        chk("fill_count_at_pop2", count, 3);
      end
      if (c >= 2 && c <= 801)
        chk($sformatf("fill_txd_t%0d", c - 2), txd, exp_bit(8'((c - 2) / 100 + 1), 9, (c - 2) % 100));
      if (c == 802) begin
        chk("fill_done_busy", busy, 0);
        chk("fill_done_count", count, 0);
        chk("fill_all_accepted", k, 9);
      end
    end
    // two stop bits, nstop change mid-frame ignored
    nstop = 1'b1;
    div = 16'd2;
    in_bits = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_frame(8'h3C, 2, 0, 5);
    nstop = 1'b0;
    check_frame(8'h3C, 2, 5, 33);
    chk("n2_done_busy", busy, 0);
    chk("n2_done_txd", txd, 1);
    // div change mid-frame applies only to the next frame
    in_bits = 8'h81;
    in_valid = 1'b1;
    tick();
    in_bits = 8'h42;
    tick();
    in_valid = 1'b0;
    check_frame(8'h81, 2, 0, 10);
    div = 16'd7;
    check_frame(8'h81, 2, 10, 30);
    check_frame(8'h42, 7, 0, 80);
    chk("div_done_busy", busy, 0);
    // reset during data bit 4 with three bytes queued
    div = 16'd1;
    in_valid = 1'b1;
    in_bits = 8'h0F;
    tick();
    in_bits = 8'h11;
    tick();
    in_bits = 8'h22;
    tick();
    in_bits = 8'h33;
    tick();
    in_valid = 1'b0;
    check_frame(8'h0F, 1, 2, 10);
    chk("abort_count_before", count, 3);
    chk("abort_bit4", txd, 0);
    reset = 1'b1;
    #1 chk("abort_ready_in_rst", in_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("abort_txd", txd, 1);
    chk("abort_count", count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk($sformatf("abort_quiet_txd%0d", i), txd, 1);
      chk($sformatf("abort_quiet_busy%0d", i), busy, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_line_tx.md
Name: uart_line_tx

Overview:
- Synthesizable DUT-side UART transmitter: the byte producer at the far end of the simulated UART host bridge.
- Accepts bytes on a valid/ready byte stream and buffers them in a small FIFO.
- Serializes each byte onto a single 8N1 or 8N2 line (`txd`) at a programmable bit period.
- Sits between the SoC's UART register block and the chip pad / line model.

Parameters:
- DATA_WIDTH, 8, bits per character; fixed at 8 for this revision.
- FIFO_DEPTH, 4, byte buffer entries; power of two, >=2.
- DIV_WIDTH, 16, width of the bit-period divisor.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  byte offered.
- in_ready  output  1  FIFO can accept a byte.
- in_bits  input  DATA_WIDTH  byte to send.
- div  input  DIV_WIDTH  bit period minus one, in clock cycles.
- nstop  input  1  0 = one stop bit, 1 = two stop bits.
- txd  output  1  serial line; idle/mark = 1.
- busy  output  1  FIFO non-empty or frame in progress.
- count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, sampled at posedge while `reset`=1:
  - FIFO cleared; FSM = IDLE; bit and baud counters = 0.
  - txd=1, busy=0, count=0.
  - in_ready=0 while `reset` is high.
- Reset mid-frame aborts the frame: txd is 1 after the next edge and queued bytes are discarded.
- Handshake:
  - in_ready = !reset && count != FIFO_DEPTH (combinational from count).
  - Push on posedge when in_valid && in_ready.
  - in_bits is sampled only on a push.
  - No bypass: every byte passes through the FIFO.
- FIFO:
  - Circular buffer with pointer wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leaves count unchanged.
  - No push is possible when full, because in_ready=0.
- FSM states: IDLE, START, DATA, STOP. All outputs are registered.
  - IDLE:
    - txd=1.
    - If count!=0: pop the head into the shift register, latch div into div_q and nstop into nstop_q, and go to START with txd<=0.
  - START: hold txd=0 for div_q+1 cycles, then go to DATA with txd<=shift[0], bit index 0.
  - DATA:
    - Each bit is held div_q+1 cycles, LSB first.
    - After bit 7 completes, go to STOP with txd<=1.
  - STOP:
    - Hold txd=1 for (nstop_q+1)*(div_q+1) cycles.
    - On completion, if count!=0: pop and go directly to START in the same edge (no idle gap between frames).
    - Otherwise go to IDLE.
- Timing:
  - A byte pushed at edge N into an empty FIFO while IDLE is popped at edge N+1.
  - txd is low from edge N+1.
  - Frame length = (10+nstop_q)*(div_q+1) cycles.
  - div=0 gives one cycle per bit.
- div and nstop changes take effect only at the next frame start; mid-frame changes are ignored.
- busy = (state!=IDLE) || (count!=0), registered-equivalent: it is derived from registered state and count, so it is glitch-free.

Test Plan:
- div=3, nstop=0, push 0xA5 once -> txd low 4 cycles starting the edge after the push, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles; busy falls after cycle 40 of the frame; count returns 0.
- div=1, push 0x00,0xFF,0x55 back-to-back -> three contiguous 20-cycle frames with no idle cycle between the stop bit and the next start bit; in_ready never drops.
- div=9, in_valid held high with bytes 0x01..0x08 -> exactly 5 accepted before in_ready=0 (one popped into the shifter, 4 in the FIFO); count=4; in_ready reasserts on the edge the 2nd byte is popped; all 8 bytes eventually emitted in order.
- nstop=1, div=2, push 0x3C -> stop phase high for 6 cycles; total frame 33 cycles; change nstop to 0 mid-frame -> current frame still uses 2 stop bits.
- Change div from 2 to 7 during the DATA phase of byte 0x81 -> that frame keeps 3-cycle bits; the next queued byte uses 8-cycle bits.
- Reset asserted for 1 cycle during DATA bit 4 with 3 bytes queued -> next edge: txd=1, count=0, busy=0, in_ready=1; no further frames emitted without new pushes.
